// File: rtl/cm_pkg.sv
// Shared definitions for the cm_* counter blocks: default widths and the
// down-counter FSM state encoding.
package cm_pkg;

    localparam int CM_DCNT_WIDTH = 8;

    typedef enum logic [1:0] {
        CM_DCNT_IDLE = 2'd0,
        CM_DCNT_RUN  = 2'd1,
        CM_DCNT_DONE = 2'd2
    } cm_dcnt_state_t;

endpackage

// File: rtl/cm_dcnt.sv
// Down-counting loop-index generator: emits N-1 .. 0 over a valid/ready handshake.
// Optional macro CM_DCNT_STEP_EN adds a per-loop decrement step (I_cnt_step).
module cm_dcnt
    import cm_pkg::*;
#(
    parameter int C_WIDTH = CM_DCNT_WIDTH
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_cnt_en,
    input  logic               I_start,
    input  logic [C_WIDTH-1:0] I_cnt_upper,
`ifdef CM_DCNT_STEP_EN
    input  logic [C_WIDTH-1:0] I_cnt_step,
`endif
    input  logic               I_cnt_ready,
    output logic               O_cnt_valid,
    output logic [C_WIDTH-1:0] O_cnt,
    output logic               O_under_flag,
    output logic               O_busy,
    output logic               O_done,
    output logic [1:0]         O_state
);

    // Handshake: an index transfers on every rising edge where O_cnt_valid and
    // I_cnt_ready are both high; O_cnt/O_under_flag hold while valid is unanswered.

    localparam logic [C_WIDTH-1:0] ONE = C_WIDTH'(1);

    cm_dcnt_state_t     r_state;
    logic               r_cnt_valid;
    logic [C_WIDTH-1:0] r_cnt;
    logic               r_under_flag;
    logic               r_busy;
    logic               r_done;

    logic [C_WIDTH-1:0] w_step_in;
    logic [C_WIDTH-1:0] w_step;
    logic [C_WIDTH-1:0] w_first;
    logic [C_WIDTH-1:0] w_next;
    logic               w_xfer;

`ifdef CM_DCNT_STEP_EN
    logic [C_WIDTH-1:0] r_step;

    // A zero step would stall the loop forever, so it degrades to 1.
    assign w_step_in = (I_cnt_step == '0) ? ONE : I_cnt_step;
    assign w_step    = r_step;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_step <= ONE;
        end else if (I_cnt_en && I_start && r_state == CM_DCNT_IDLE) begin
            r_step <= w_step_in;
        end
    end
`else
    assign w_step_in = ONE;
    assign w_step    = ONE;
`endif

    assign w_first = I_cnt_upper - ONE;
    assign w_next  = r_cnt - w_step;
    assign w_xfer  = r_cnt_valid & I_cnt_ready;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state      <= CM_DCNT_IDLE;
            r_cnt_valid  <= 1'b0;
            r_cnt        <= '0;
            r_under_flag <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (!I_cnt_en) begin
            r_state      <= CM_DCNT_IDLE;
            r_cnt_valid  <= 1'b0;
            r_cnt        <= '0;
            r_under_flag <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                CM_DCNT_IDLE: begin
                    r_done <= 1'b0;
                    if (I_start) begin
                        r_busy <= 1'b1;
                        if (I_cnt_upper != '0) begin
                            r_state      <= CM_DCNT_RUN;
                            r_cnt        <= w_first;
                            r_cnt_valid  <= 1'b1;
                            r_under_flag <= (w_first < w_step_in);
                        end else begin
                            r_state <= CM_DCNT_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                CM_DCNT_RUN: begin
                    if (w_xfer) begin
                        if (r_under_flag) begin
                            r_state      <= CM_DCNT_DONE;
                            r_cnt_valid  <= 1'b0;
                            r_cnt        <= '0;
                            r_under_flag <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            // Flag is clear only when r_cnt >= step, so this cannot wrap.
                            r_cnt        <= w_next;
                            r_under_flag <= (w_next < w_step);
                        end
                    end
                end
                CM_DCNT_DONE: begin
                    r_state <= CM_DCNT_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= CM_DCNT_IDLE;
                    r_cnt_valid  <= 1'b0;
                    r_cnt        <= '0;
                    r_under_flag <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign O_cnt_valid  = r_cnt_valid;
    assign O_cnt        = r_cnt;
    assign O_under_flag = r_under_flag;
    assign O_busy       = r_busy;
    assign O_done       = r_done;
    assign O_state      = r_state;

endmodule
